// File: rtl/load_store_unit_if.sv
// Core-side request/response and data-memory bus of the load/store unit.
// The LSU connects through the slave modport; the core/memory environment
// connects through the master modport.
interface load_store_unit_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  // Core request channel
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [2:0]               req_funct3;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;

  // Core response channel
  logic                     rsp_valid;
  logic                     rsp_err;
  logic [DATA_WIDTH-1:0]    rsp_rdata;

  // Word-addressed data memory port
  logic                     mem_we;
  logic [ADDRESS_WIDTH-3:0] mem_address;
  logic [DATA_WIDTH-1:0]    mem_writeData;
  logic [DATA_WIDTH-1:0]    mem_readData;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_readData,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
           mem_we, mem_address, mem_writeData
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_readData,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
           mem_we, mem_address, mem_writeData
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns RISC-V byte/half/word loads and stores into whole-word
// accesses on a memory with one-cycle synchronous read. Sub-word stores use a
// read-modify-write; loads extract and sign/zero-extend the addressed lane.
module load_store_unit #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input logic             clk,
  input logic             rst_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LD_EXT,
    WR,
    RMW_WR
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_e state_q, state_d;

  // Request latched at accept; req_* is ignored afterwards
  logic                     we_q;
  logic [2:0]               funct3_q;
  logic [1:0]               off_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [ADDRESS_WIDTH-3:0] mem_addr_q;

  logic                     rsp_valid_q, rsp_valid_d;
  logic                     rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;

  logic                     accept;
  logic                     req_illegal;

  // Select the addressed byte/half of a word and extend it; funct3[2] selects zero-extension
  function automatic logic [DATA_WIDTH-1:0] extract(input logic [DATA_WIDTH-1:0] word,
                                                    input logic [2:0] f3,
                                                    input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3[1:0])
      2'b00:   extract = {{(DATA_WIDTH-8){b[7] & ~f3[2]}}, b};
      2'b01:   extract = {{(DATA_WIDTH-16){h[15] & ~f3[2]}}, h};
      default: extract = word;
    endcase
  endfunction

  // Replace the addressed byte/half of the old word with the store data
  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] word,
                                                  input logic [2:0] f3,
                                                  input logic [1:0] off,
                                                  input logic [DATA_WIDTH-1:0] wdata);
    merge = word;
    if (f3[0]) begin
      if (off[1]) merge[31:16] = wdata[15:0];
      else        merge[15:0]  = wdata[15:0];
    end else begin
      case (off)
        2'd0:    merge[7:0]   = wdata[7:0];
        2'd1:    merge[15:8]  = wdata[7:0];
        2'd2:    merge[23:16] = wdata[7:0];
        default: merge[31:24] = wdata[7:0];
      endcase
    end
  endfunction

  // Illegal funct3, misalignment, or an unsigned-width store is rejected at accept
  always_comb begin
    // NOTE: every variable written here gets a default first so no path infers a latch.
    req_illegal = 1'b1;
    case (bus.req_funct3)
      F3_B, F3_BU: req_illegal = bus.req_we & bus.req_funct3[2];
      F3_H, F3_HU: req_illegal = bus.req_addr[0] | (bus.req_we & bus.req_funct3[2]);
      F3_W:        req_illegal = (bus.req_addr[1:0] != 2'b00);
      default:     req_illegal = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and response values
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (req_illegal) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (bus.req_we && (bus.req_funct3 == F3_W)) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD:     state_d = we_q ? RMW_WR : LD_EXT;
      LD_EXT: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = extract(bus.mem_readData, funct3_q, off_q);
      end
      WR, RMW_WR: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q     <= bus.req_we;
        funct3_q <= bus.req_funct3;
        off_q    <= bus.req_addr[1:0];
        wdata_q  <= bus.req_wdata;
        // Rejected requests never touch memory, so the word address keeps its last value
        if (!req_illegal) mem_addr_q <= bus.req_addr[ADDRESS_WIDTH-1:2];
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Memory write port is driven purely from state and the latched request
  always_comb begin
    bus.mem_we        = 1'b0;
    bus.mem_writeData = '0;
    case (state_q)
      WR: begin
        bus.mem_we        = 1'b1;
        bus.mem_writeData = wdata_q;
      end
      RMW_WR: begin
        bus.mem_we        = 1'b1;
        bus.mem_writeData = merge(bus.mem_readData, funct3_q, off_q, wdata_q);
      end
      default: ;
    endcase
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.mem_address = mem_addr_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word memory model and a
// response scoreboard (expected err/rdata/latency queued at accept).
module tb_load_store_unit;
  localparam int AW = 32;
  localparam int DW = 32;

  localparam logic [2:0] B  = 3'b000;
  localparam logic [2:0] H  = 3'b001;
  localparam logic [2:0] W  = 3'b010;
  localparam logic [2:0] BU = 3'b100;
  localparam logic [2:0] HU = 3'b101;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  load_store_unit #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Word memory: one-cycle registered read, read data held during a write
  logic [31:0] mem [0:63] = '{default: 32'h0};
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_address[5:0]] <= bus.mem_writeData;
    else            bus.mem_readData <= mem[bus.mem_address[5:0]];
  end

  // Cycle counter and write monitor
  int unsigned cyc    = 0;
  int unsigned we_cnt = 0;
  logic [29:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_we) begin
      we_cnt       <= we_cnt + 1;
      last_wr_addr <= bus.mem_address;
      last_wr_data <= bus.mem_writeData;
    end
  end

  typedef struct {
    string       tag;
    logic        err;
    logic [31:0] rdata;
    int unsigned lat;
    int unsigned acc;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int unsigned we0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request from a negedge; queue the expected response at accept
  task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_rdata,
                       input int unsigned lat);
    exp_t e;
    int   waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " ready"}, bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1;
    e.tag = tag; e.err = exp_err; e.rdata = exp_rdata; e.lat = lat; e.acc = cyc;
    sb_q.push_back(e);
    // Scramble the request after accept; the DUT must use its latched copy
    bus.req_valid  = 1'b0;
    bus.req_we     = ~we;
    bus.req_funct3 = W;
    bus.req_addr   = ~addr;
    bus.req_wdata  = ~wdata;
    @(negedge clk);
  endtask

  // Wait (bounded) for the response pulse and compare against the scoreboard head
  task automatic wait_rsp();
    exp_t e;
    int   n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    e = sb_q.pop_front();
    check({e.tag, " valid"},   bus.rsp_valid, 1);
    check({e.tag, " err"},     bus.rsp_err, e.err);
    check({e.tag, " rdata"},   bus.rsp_rdata, e.rdata);
    check({e.tag, " latency"}, cyc - e.acc, e.lat);
  endtask

  task automatic op(input string tag, input logic we, input logic [2:0] f3,
                    input logic [31:0] addr, input logic [31:0] wdata,
                    input logic exp_err, input logic [31:0] exp_rdata,
                    input int unsigned lat);
    issue(tag, we, f3, addr, wdata, exp_err, exp_rdata, lat);
    wait_rsp();
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    rst_n          = 1'b1;

    // Reset asserted mid-cycle: outputs take reset values at once
    #2 rst_n = 1'b0;
    #1;
    check("rst req_ready",     bus.req_ready, 1);
    check("rst rsp_valid",     bus.rsp_valid, 0);
    check("rst rsp_err",       bus.rsp_err, 0);
    check("rst rsp_rdata",     bus.rsp_rdata, 0);
    check("rst mem_we",        bus.mem_we, 0);
    check("rst mem_address",   bus.mem_address, 0);
    check("rst mem_writeData", bus.mem_writeData, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // SW then LW at 0x10
    we0 = we_cnt;
    op("sw_10", 1'b1, W, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1);
    check("sw_10 we_cnt",  we_cnt - we0, 1);
    check("sw_10 wr_addr", last_wr_addr, 4);
    check("sw_10 wr_data", last_wr_data, 32'hDEADBEEF);
    @(negedge clk);
    check("sw_10 pulse_width", bus.rsp_valid, 0);
    op("lw_10", 1'b0, W, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2);
    @(negedge clk);
    check("lw_10 rdata_hold", bus.rsp_rdata, 32'hDEADBEEF);

    // Byte store and byte loads over 0x11223344
    op("sw_pre1", 1'b1, W,  32'h10, 32'h11223344, 1'b0, 32'h0, 1);
    op("sb_13",   1'b1, B,  32'h13, 32'h123456A5, 1'b0, 32'h0, 2);
    check("sb_13 mem", mem[4], 32'hA5223344);
    op("lb_13",   1'b0, B,  32'h13, 32'h0, 1'b0, 32'hFFFFFFA5, 2);
    op("lbu_13",  1'b0, BU, 32'h13, 32'h0, 1'b0, 32'h000000A5, 2);
    op("lb_10",   1'b0, B,  32'h10, 32'h0, 1'b0, 32'h00000044, 2);
    op("lb_11",   1'b0, B,  32'h11, 32'h0, 1'b0, 32'h00000033, 2);
    op("lbu_12",  1'b0, BU, 32'h12, 32'h0, 1'b0, 32'h00000022, 2);

    // Half store and half loads over 0x11223344
    op("sw_pre2", 1'b1, W,  32'h10, 32'h11223344, 1'b0, 32'h0, 1);
    op("sh_12",   1'b1, H,  32'h12, 32'hABCD8001, 1'b0, 32'h0, 2);
    check("sh_12 mem", mem[4], 32'h80013344);
    op("lh_12",   1'b0, H,  32'h12, 32'h0, 1'b0, 32'hFFFF8001, 2);
    op("lhu_12",  1'b0, HU, 32'h12, 32'h0, 1'b0, 32'h00008001, 2);
    op("lh_10",   1'b0, H,  32'h10, 32'h0, 1'b0, 32'h00003344, 2);
    op("sh_10",   1'b1, H,  32'h10, 32'h0000F00F, 1'b0, 32'h0, 2);
    check("sh_10 mem", mem[4], 32'h8001F00F);
    op("lh_10b",  1'b0, H,  32'h10, 32'h0, 1'b0, 32'hFFFFF00F, 2);

    // Errors: no memory write, address held, back-to-back accepts
    op("sw_20",   1'b1, W,  32'h20, 32'h0BADC0DE, 1'b0, 32'h0, 1);
    op("lw_20",   1'b0, W,  32'h20, 32'h0, 1'b0, 32'h0BADC0DE, 2);
    we0 = we_cnt;
    op("lw_11",   1'b0, W,      32'h11, 32'h0, 1'b1, 32'h0, 0);
    op("sh_13",   1'b1, H,      32'h13, 32'hFFFF, 1'b1, 32'h0, 0);
    op("f3_011",  1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 0);
    op("sbu_st",  1'b1, BU,     32'h10, 32'h5A, 1'b1, 32'h0, 0);
    op("lhu_11",  1'b0, HU,     32'h11, 32'h0, 1'b1, 32'h0, 0);
    check("err no_write",  we_cnt - we0, 0);
    check("err addr_hold", bus.mem_address, 8);
    op("lw_after_err", 1'b0, W, 32'h20, 32'h0, 1'b0, 32'h0BADC0DE, 2);

    // Reset during the merged write of an SB: write abandoned, no response
    op("sw_pre3", 1'b1, W, 32'h10, 32'hCAFEF00D, 1'b0, 32'h0, 1);
    we0 = we_cnt;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = B;
    bus.req_addr   = 32'h11;
    bus.req_wdata  = 32'h55;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rmw we_on",   bus.mem_we, 1);
    check("rmw wr_data", bus.mem_writeData, 32'hCAFE550D);
    #1 rst_n = 1'b0;
    #1;
    check("rmw_rst mem_we",        bus.mem_we, 0);
    check("rmw_rst req_ready",     bus.req_ready, 1);
    check("rmw_rst rsp_valid",     bus.rsp_valid, 0);
    check("rmw_rst mem_writeData", bus.mem_writeData, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rmw_rst no_rsp", bus.rsp_valid, 0);
    end
    check("rmw_rst mem",    mem[4], 32'hCAFEF00D);
    check("rmw_rst we_cnt", we_cnt - we0, 0);
    op("lw_post_rst", 1'b0, W, 32'h10, 32'h0, 1'b0, 32'hCAFEF00D, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the CPU execute stage and the data memory; data memory holds DATA_WIDTH-bit words, has one-cycle synchronous read and whole-word write only. Converts RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses. Does alignment checking, byte-lane extraction with sign/zero extension, and read-modify-write for sub-word stores. Presents a valid/ready request and one-cycle response pulse to the core; the core stalls while `req_ready` is low.

## Interface
- ADDRESS_WIDTH, 32, byte-address width from the core; memory word address is ADDRESS_WIDTH-2 bits
- DATA_WIDTH, 32, word width; fixed at 32 (four byte lanes)
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request accepted on edge with req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  ADDRESS_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-aligned
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  qualifies rsp_valid: misaligned or illegal funct3
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores/errors
- mem_we  out  1  to data memory write enable
- mem_address  out  ADDRESS_WIDTH-2  word address = addr[ADDRESS_WIDTH-1:2]
- mem_writeData  out  DATA_WIDTH  word to write
- mem_readData  in  DATA_WIDTH  registered read data from memory

## Operation
- States: IDLE, RD (memory read cycle), LD_EXT (load extract), WR (full-word write), RMW_WR (merged write).
- Accept in IDLE latches we, funct3, addr, wdata; later req_* changes ignored.
- Error check at accept: H/HU with addr[0]=1, W with addr[1:0]!=0, funct3 011/110/111, or store with funct3[2]=1 -> no memory access; rsp_valid=1, rsp_err=1, rsp_rdata=0 next cycle; stay IDLE.
- Load: IDLE -> RD -> LD_EXT -> IDLE. In LD_EXT select lane from latched addr[1:0] (byte) or addr[1] (half), sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1); register into rsp_rdata, rsp_valid=1.
- SW: IDLE -> WR -> IDLE; mem_we=1, mem_writeData=latched wdata; rsp_valid=1 after write edge.
- SB/SH: IDLE -> RD -> RMW_WR -> IDLE. RMW_WR drives mem_we=1, mem_writeData = mem_readData with addressed byte/half replaced by wdata[7:0]/[15:0]; others preserved. Memory holds readData while we=1, so mem_readData is stable in RMW_WR.
- mem_we and mem_address come only from state and latched request, never from req_*. mem_writeData is combinational from mem_readData only in RMW_WR.
- mem_we=1 only in WR and RMW_WR. mem_address holds the last value while IDLE.

## Timing
- Reset (async, immediate): state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we=0, mem_address=0, mem_writeData=0.
- Accept at edge E0. rsp_valid high for exactly one cycle after: E0 (error), E1 (SW), E2 (load, SB/SH).
- req_ready low from E0 until the edge that raises rsp_valid. A new request may be accepted in the rsp_valid cycle, giving back-to-back operation.
- rsp_rdata holds until the next response; rsp_err is cleared on every non-error response.
- Reset mid-operation: mem_we drops asynchronously; any write whose edge has not occurred is abandoned and the memory word is unchanged; no rsp_valid for the abandoned request.
- Store-then-load to the same word: load sees the new data, since the store completes before the next accept.

## Test plan
- Reset with rst_n=0 mid-cycle -> all outputs at reset values immediately; req_ready=1.
- SW 0xDEADBEEF @0x10, then LW @0x10 -> mem_address=4, mem_we=1 for one cycle; LW rsp_rdata=0xDEADBEEF, rsp_valid 3 cycles after the request cycle.
- Word @0x10 = 0x11223344; SB 0xA5 @0x13 -> word 0xA5223344; LB @0x13 -> 0xFFFFFFA5; LBU -> 0x000000A5; LB @0x10 -> 0x00000044.
- SH 0x8001 @0x12 over 0x11223344 -> 0x80013344; LH @0x12 -> 0xFFFF8001; LHU -> 0x00008001.
- LW @0x11, SH @0x13, funct3=011 -> each gives rsp_valid=1, rsp_err=1, rsp_rdata=0 one cycle after accept; mem_we never asserted.
- SB accepted, rst_n pulsed low during RMW_WR -> mem_we falls, memory word unchanged, no rsp_valid; next LW returns the original word.
